rowwise_issue: RTL and testbench

ROWWISE_ISSUE -- requirements
Module: rowwise_issue

---
 rtl/config_pkg.sv | 37 +++
 rtl/rowwise_cmd_fifo.sv | 57 +++++
 rtl/rowwise_issue.sv | 122 ++++++++++++
 tb/tb_rowwise_issue.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types for the rowwise issue path.
//   D            : elements per vector; the rowwise unit spends one BUSY cycle per element
//   ELEM_W       : element width (signed Q8.8 fixed point, 1.0 = 16'h0100)
//   TAG_W_DEF    : default command tag width (fixes the width of issue_cmd_t.tag)
//   vector_t     : packed vector of D elements, element 0 in the low bits
//   operation_t  : element-wise operation requested from the rowwise unit
//   issue_cmd_t  : one queued command {op, a, b, tag}
//   issue_state_t: issue controller states
package config_pkg;

  localparam int D         = 4;
  localparam int ELEM_W    = 16;
  localparam int TAG_W_DEF = 4;

  typedef logic [D-1:0][ELEM_W-1:0] vector_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } operation_t;

  typedef struct packed {
    operation_t             op;
    vector_t                a;
    vector_t                b;
    logic [TAG_W_DEF-1:0]   tag;
  } issue_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } issue_state_t;

endpackage

// File: rtl/rowwise_cmd_fifo.sv
// Command FIFO, DEPTH entries of issue_cmd_t, valid/ready on both sides.
//   clk_i, rst_ni        : clock, asynchronous active-low reset (empties the FIFO)
//   in_valid/in_ready    : write side; in_ready = not full (no write-through when full)
//   in_data              : command written at the tail
//   out_valid/out_ready  : read side; out_valid = not empty
//   out_data             : command at the head
module rowwise_cmd_fifo
  import config_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid,
  output logic       in_ready,
  input  issue_cmd_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output issue_cmd_t out_data
);

  localparam int AW = $clog2(DEPTH);

  issue_cmd_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/rowwise_issue.sv
// Issues queued vector commands to a multi-cycle rowwise unit, one at a time,
// and presents each finished result with its tag in push order.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   cmd_*                         : command push interface into the FIFO
//   fu_valid_o/fu_ready_i         : issue handshake with the rowwise unit
//   fu_op_o/fu_a_o/fu_b_o         : latched operands of the command in flight
//   fu_old_result_o               : result register fed back to the unit
//   fu_new_result_i               : unit's updated result, captured every BUSY cycle
//   done_*                        : finished result/tag, held until accepted
//
// state  | meaning
// IDLE   | offer FIFO head to the unit; pop and latch it on handshake
// BUSY   | D cycles capturing fu_new_result_i into the result register
// DONE   | result and tag presented; wait for done_ready_i
module rowwise_issue
  import config_pkg::*;
#(
  parameter int CMD_DEPTH = 2,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  operation_t       cmd_op_i,
  input  vector_t          cmd_a_i,
  input  vector_t          cmd_b_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic             fu_valid_o,
  input  logic             fu_ready_i,
  output operation_t       fu_op_o,
  output vector_t          fu_a_o,
  output vector_t          fu_b_o,
  output vector_t          fu_old_result_o,
  input  vector_t          fu_new_result_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output vector_t          done_result_o,
  output logic [TAG_W-1:0] done_tag_o
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;

  issue_state_t     state_q;
  logic [CW-1:0]    cnt_q;
  operation_t       op_q;
  vector_t          a_q;
  vector_t          b_q;
  logic [TAG_W-1:0] tag_q;
  vector_t          result_q;

  issue_cmd_t in_cmd;
  issue_cmd_t head;
  logic       head_valid;
  logic       head_ready;
  logic       issue;

  assign in_cmd = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i, tag: cmd_tag_i};

  // The FIFO is only drained from IDLE, so DONE blocks any new issue.
  assign head_ready = (state_q == S_IDLE) && fu_ready_i;
  assign issue      = head_ready && head_valid;

  rowwise_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (cmd_valid_i),
    .in_ready  (cmd_ready_o),
    .in_data   (in_cmd),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            op_q     <= head.op;
            a_q      <= head.a;
            b_q      <= head.b;
            tag_q    <= head.tag;
            result_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          result_q <= fu_new_result_i;
          // Counter stops at D-1; it is cleared again on the next issue.
          if (cnt_q == CW'(D - 1)) state_q <= S_DONE;
          else                     cnt_q   <= cnt_q + 1'b1;
        end
        S_DONE: begin
          if (done_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fu_valid_o      = (state_q == S_IDLE) && head_valid;
  assign fu_op_o         = op_q;
  assign fu_a_o          = a_q;
  assign fu_b_o          = b_q;
  assign fu_old_result_o = result_q;
  assign done_valid_o    = (state_q == S_DONE);
  assign done_result_o   = result_q;
  assign done_tag_o      = tag_q;

endmodule

// File: tb/tb_rowwise_issue.sv
module tb_rowwise_issue;
  import config_pkg::*;

  localparam int DEPTH = 2;
  localparam int TW    = TAG_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  operation_t    cmd_op = OP_ADD;
  vector_t       cmd_a = '0;
  vector_t       cmd_b = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          fu_valid;
  logic          fu_ready = 1'b0;
  operation_t    fu_op;
  vector_t       fu_a;
  vector_t       fu_b;
  vector_t       fu_old;
  vector_t       fu_new;
  logic          done_valid;
  logic          done_ready = 1'b0;
  vector_t       done_res;
  logic [TW-1:0] done_tag;

  always #5 clk = ~clk;

  rowwise_issue #(.CMD_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_a_i         (cmd_a),
    .cmd_b_i         (cmd_b),
    .cmd_tag_i       (cmd_tag),
    .fu_valid_o      (fu_valid),
    .fu_ready_i      (fu_ready),
    .fu_op_o         (fu_op),
    .fu_a_o          (fu_a),
    .fu_b_o          (fu_b),
    .fu_old_result_o (fu_old),
    .fu_new_result_i (fu_new),
    .done_valid_o    (done_valid),
    .done_ready_i    (done_ready),
    .done_result_o   (done_res),
    .done_tag_o      (done_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ELEM_W-1:0] elem_op(input operation_t op,
                                                input logic [ELEM_W-1:0] x,
                                                input logic [ELEM_W-1:0] y);
    logic signed [ELEM_W-1:0] sx;
    logic signed [ELEM_W-1:0] sy;
    sx = x;
    sy = y;
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_MAX:  return (sx > sy) ? x : y;
      default: return (sx < sy) ? x : y;
    endcase
  endfunction

  // Ideal rowwise unit: fills in one element per BUSY cycle, element 0 first.
  int fu_idx = D;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     fu_idx <= D;
    else if (fu_valid && fu_ready)  fu_idx <= 0;
    else if (fu_idx < D)            fu_idx <= fu_idx + 1;
  end

  always_comb begin
    fu_new = fu_old;
    if (fu_idx < D) fu_new[fu_idx] = elem_op(fu_op, fu_a[fu_idx], fu_b[fu_idx]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    operation_t    op;
    vector_t       a;
    vector_t       b;
    logic [TW-1:0] tag;
  } mcmd_t;

  mcmd_t         mq[$];
  mcmd_t         job;
  mcmd_t         last_ops;
  bit            job_on;
  int            job_k;        // 1..D: BUSY cycle index; >D: waiting in DONE
  vector_t       held;
  int            hs_cyc[$];
  bit            m_push;
  vector_t       exp_old;

  function automatic vector_t partial(input mcmd_t c, input int n);
    vector_t v;
    v = '0;
    for (int i = 0; i < D; i++)
      if (i < n) v[i] = elem_op(c.op, c.a[i], c.b[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      job_on   = 1'b0;
      job_k    = 0;
      held     = '0;
      last_ops = '{op: OP_ADD, a: '0, b: '0, tag: '0};
    end
    if (!job_on)          exp_old = held;
    else if (job_k <= D)  exp_old = partial(job, job_k - 1);
    else                  exp_old = partial(job, D);

    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("fu_valid", fu_valid, !job_on && mq.size() > 0);
    chk("done_valid", done_valid, job_on && job_k > D);
    chk("fu_old_result", fu_old, exp_old);
    chk("fu_op", fu_op, last_ops.op);
    chk("fu_a", fu_a, last_ops.a);
    chk("fu_b", fu_b, last_ops.b);
    if (job_on && job_k > D) begin
      chk("done_result", done_res, partial(job, D));
      chk("done_tag", done_tag, job.tag);
    end

    if (rst_n) begin
      m_push = cmd_valid && (mq.size() < DEPTH);
      if (!job_on) begin
        if (mq.size() > 0 && fu_ready) begin
          job      = mq.pop_front();
          last_ops = job;
          job_on   = 1'b1;
          job_k    = 1;
          hs_cyc.push_back(cyc);
        end
      end else if (job_k > D) begin
        if (done_ready) begin
          held   = partial(job, D);
          job_on = 1'b0;
        end
      end else begin
        job_k++;
      end
      if (m_push) mq.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag});
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic vector_t rand_vec();
    vector_t v;
    for (int i = 0; i < D; i++) v[i] = ELEM_W'($urandom);
    return v;
  endfunction

  // Called just after a rising edge; returns the cycle in which the push happened.
  task automatic push_cmd(input operation_t op, input vector_t a, input vector_t b,
                          input logic [TW-1:0] tag, output int at);
    int g;
    g = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    do begin
      @(negedge clk);
      g++;
    end while (!cmd_ready && g < 200);
    at = cyc;
    if (!cmd_ready) fail_now("push_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int at, output vector_t res, output logic [TW-1:0] tg);
    int g;
    g   = 0;
    at  = -1;
    res = '0;
    tg  = '0;
    do begin
      @(negedge clk);
      g++;
    end while (!done_valid && g < 100);
    if (done_valid) begin
      at  = cyc;
      res = done_res;
      tg  = done_tag;
    end else begin
      fail_now("done_timeout");
    end
  endtask

  initial begin
    int            t;
    int            t2;
    int            at;
    int            n0;
    int            seen;
    vector_t       res;
    vector_t       cap_res;
    logic [TW-1:0] tg;
    logic [TW-1:0] cap_tg;
    vector_t       va;
    vector_t       vb;
    vector_t       ve;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_done_tag", done_tag, 0);
    rst_n = 1'b1;

    // Single ADD: 2.0 + 1.0 = 3.0 everywhere, done D+2 cycles after the push.
    fu_ready   = 1'b1;
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(OP_ADD, {D{16'h0200}}, {D{16'h0100}}, 4'd3, t);
    wait_done(at, res, tg);
    chk("t1_handshake_cycle", hs_cyc[hs_cyc.size()-1], t + 1);
    chk("t1_done_cycle", at, t + D + 2);
    ve = {D{16'h0300}};
    chk("t1_result", res, ve);
    chk("t1_tag", tg, 3);

    // SUB with a[i]=i, b[i]=1 -> result[i]=i-1.
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      va[i] = 16'(i * 256);
      vb[i] = 16'h0100;
    end
    push_cmd(OP_SUB, va, vb, 4'd9, t);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ve = '0;
    ve[0] = 16'hFF00;
    chk("t2_partial_at_busy3", fu_old, ve);
    wait_done(at, res, tg);
    ve[1] = 16'h0000;
    ve[2] = 16'h0100;
    ve[3] = 16'h0200;
    chk("t2_sub_result", res, ve);
    chk("t2_tag", tg, 9);

    // Fill the FIFO with the unit stalled: third push must stall, nothing pops.
    @(posedge clk);
    #1;
    fu_ready = 1'b0;
    n0 = hs_cyc.size();
    for (int k = 0; k < DEPTH + 1; k++) begin
      cmd_valid = 1'b1;
      cmd_op    = operation_t'($urandom_range(3));
      cmd_a     = rand_vec();
      cmd_b     = rand_vec();
      cmd_tag   = TW'(4 + k);
      @(negedge clk);
      if (k == DEPTH) begin
        chk("t3_full_stall", cmd_ready, 0);
        chk("t3_head_offered", fu_valid, 1);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_no_pop", hs_cyc.size(), n0);
    fu_ready = 1'b1;
    wait_done(at, res, tg);
    chk("t3_first_tag", tg, 4);
    wait_done(at, res, tg);
    chk("t3_second_tag", tg, 5);

    // Tags 1,2,3 back-to-back with the consumer always ready.
    @(posedge clk);
    #1;
    n0 = hs_cyc.size();
    push_cmd(OP_MAX, rand_vec(), rand_vec(), 4'd1, t);
    push_cmd(OP_MIN, rand_vec(), rand_vec(), 4'd2, t);
    push_cmd(OP_ADD, rand_vec(), rand_vec(), 4'd3, t);
    wait_done(at, res, tg);
    chk("t4_tag1", tg, 1);
    wait_done(at, res, tg);
    chk("t4_tag2", tg, 2);
    wait_done(at, res, tg);
    chk("t4_tag3", tg, 3);
    if (hs_cyc.size() >= n0 + 3) begin
      chk("t4_gap12", hs_cyc[n0+1] - hs_cyc[n0], D + 2);
      chk("t4_gap23", hs_cyc[n0+2] - hs_cyc[n0+1], D + 2);
    end else begin
      fail_now("t4_handshakes");
    end

    // Consumer stalls 10 cycles in DONE with another command queued.
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    push_cmd(OP_SUB, rand_vec(), rand_vec(), 4'd7, t);
    push_cmd(OP_ADD, rand_vec(), rand_vec(), 4'd8, t);
    wait_done(at, cap_res, cap_tg);
    chk("t5_tag", cap_tg, 7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_result", done_res, cap_res);
      chk("t5_hold_tag", done_tag, cap_tg);
      chk("t5_no_issue", fu_valid, 0);
    end
    @(posedge clk);
    #1;
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_idle_after_accept", done_valid, 0);
    chk("t5_next_offered", fu_valid, 1);
    wait_done(at, res, tg);
    chk("t5_next_tag", tg, 8);

    // Reset during the second BUSY cycle discards in-flight and queued commands.
    @(posedge clk);
    #1;
    push_cmd(OP_ADD, rand_vec(), rand_vec(), 4'd11, t);
    push_cmd(OP_ADD, rand_vec(), rand_vec(), 4'd12, t2);
    @(posedge clk);
    #1;
    chk("t6_in_busy2", cyc, t + 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_fu_valid", fu_valid, 0);
    chk("t6_rst_done_valid", done_valid, 0);
    chk("t6_rst_fu_old", fu_old, 0);
    chk("t6_rst_fu_a", fu_a, 0);
    chk("t6_rst_done_tag", done_tag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_valid || fu_valid) seen++;
    end
    chk("t6_nothing_after_reset", seen, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      cmd_valid  = ($urandom_range(1) == 1);
      cmd_op     = operation_t'($urandom_range(3));
      cmd_a      = rand_vec();
      cmd_b      = rand_vec();
      cmd_tag    = TW'($urandom);
      fu_ready   = ($urandom_range(3) != 0);
      done_ready = ($urandom_range(4) < 3);
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    fu_ready   = 1'b1;
    done_ready = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("drain_fifo_empty", fu_valid, 0);
    chk("drain_no_done", done_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
